press_accumulator: RTL and testbench



---
 rtl/press_accumulator_pkg.sv | 21 ++
 rtl/press_accumulator_bcd_digit_step.sv | 41 ++++
 rtl/press_accumulator.sv | 161 ++++++++++++++++
 tb/tb_press_accumulator.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/press_accumulator_pkg.sv
// Shared types and constants for the press accumulator: press codes,
// controller states and BCD helpers.
package press_pkg;

  localparam int BCD_W = 4;

  localparam logic [1:0] PRESS_ONE = 2'b01;
  localparam logic [1:0] PRESS_TEN = 2'b10;

  typedef enum logic {
    ENTRY = 1'b0,
    RUN   = 1'b1
  } state_t;

  // Two BCD digits to binary; callers keep digits <= 9 so 7 bits suffice.
  function automatic logic [6:0] bcd_to_bin(input logic [BCD_W-1:0] tens,
                                            input logic [BCD_W-1:0] ones);
    bcd_to_bin = ({3'b000, tens} * 7'd10) + {3'b000, ones};
  endfunction

endpackage

// File: rtl/press_accumulator_bcd_digit_step.sv
// Single BCD digit stepped by one in either direction, with
// carry (up) or borrow (down) rippled to the next digit.
module bcd_digit_step
  import press_pkg::*;
(
  input  logic [BCD_W-1:0] digit,
  input  logic             up,
  input  logic             step_in,
  output logic [BCD_W-1:0] digit_next,
  output logic             step_out
);

  // Increment wraps 9->0 with carry, decrement wraps 0->9 with borrow.
  always_comb begin
    digit_next = digit;
    step_out   = 1'b0;
    if (step_in) begin
      if (up) begin
        if (digit >= 4'd9) begin
          digit_next = 4'd0;
          step_out   = 1'b1;
        end else begin
          digit_next = digit + 4'd1;
          step_out   = 1'b0;
        end
      end else begin
        if (digit == 4'd0) begin
          digit_next = 4'd9;
          step_out   = 1'b1;
        end else begin
          digit_next = digit - 4'd1;
          step_out   = 1'b0;
        end
      end
    end else begin
      digit_next = digit;
      step_out   = 1'b0;
    end
  end

endmodule

// File: rtl/press_accumulator.sv
// Accumulates +1/+10 button presses into a saturating two-digit BCD value
// and, in RUN, counts it down to zero at one step per TICK_DIV cycles.
module press_accumulator
  import press_pkg::*;
#(
  parameter int MAX_VALUE = 99,
  parameter int TICK_DIV  = 100_000_000,
  parameter int TICK_W    = 27
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       press_valid,
  input  logic [1:0] press_type,
  input  logic       toggle,
  input  logic       clear,
  output logic [3:0] value_ones,
  output logic [3:0] value_tens,
  output logic       running,
  output logic       done,
  output logic       overflow
);

  localparam logic [6:0]        MAX_BIN   = 7'(MAX_VALUE);
  localparam logic [BCD_W-1:0]  MAX_TENS  = BCD_W'(MAX_VALUE / 10);
  localparam logic [BCD_W-1:0]  MAX_ONES  = BCD_W'(MAX_VALUE % 10);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);

  state_t             state_r, state_nxt_s;
  logic [BCD_W-1:0]   ones_r, tens_r, ones_nxt_s, tens_nxt_s;
  logic [TICK_W-1:0]  tick_r, tick_nxt_s;
  logic               toggle_q_r;
  logic               running_r, done_r, overflow_r;
  logic               done_nxt_s, overflow_nxt_s;

  logic               in_entry_s, add_one_s, add_ten_s, toggle_rise_s, tick_hit_s;
  logic               ones_step_in_s, tens_step_in_s;
  logic [BCD_W-1:0]   ones_step_s, tens_step_s;
  logic               ones_co_s, tens_co_s;
  logic [6:0]         sum_bin_s;

  assign in_entry_s    = (state_r == ENTRY);
  assign add_one_s     = in_entry_s && press_valid && (press_type == PRESS_ONE);
  assign add_ten_s     = in_entry_s && press_valid && (press_type == PRESS_TEN);
  assign toggle_rise_s = toggle && !toggle_q_r;
  assign tick_hit_s    = (state_r == RUN) && (tick_r == TICK_LAST);

  // Both digits share direction: up while entering, down while running.
  assign ones_step_in_s = in_entry_s ? add_one_s : tick_hit_s;
  assign tens_step_in_s = in_entry_s ? (add_ten_s || ones_co_s) : ones_co_s;

  bcd_digit_step u_ones (
    .digit      (ones_r),
    .up         (in_entry_s),
    .step_in    (ones_step_in_s),
    .digit_next (ones_step_s),
    .step_out   (ones_co_s)
  );

  bcd_digit_step u_tens (
    .digit      (tens_r),
    .up         (in_entry_s),
    .step_in    (tens_step_in_s),
    .digit_next (tens_step_s),
    .step_out   (tens_co_s)
  );

  assign sum_bin_s = bcd_to_bin(tens_r, ones_r) + (add_ten_s ? 7'd10 : (add_one_s ? 7'd1 : 7'd0));

  // Next-state, next-value and pulse computation.
  always_comb begin
    state_nxt_s    = state_r;
    ones_nxt_s     = ones_r;
    tens_nxt_s     = tens_r;
    tick_nxt_s     = tick_r;
    done_nxt_s     = 1'b0;
    overflow_nxt_s = 1'b0;
    if (clear) begin
      state_nxt_s = ENTRY;
      ones_nxt_s  = 4'd0;
      tens_nxt_s  = 4'd0;
      tick_nxt_s  = TICK_W'(0);
    end else begin
      case (state_r)
        ENTRY: begin
          tick_nxt_s = TICK_W'(0);
          if (add_one_s || add_ten_s) begin
            if ((sum_bin_s > MAX_BIN) || tens_co_s) begin
              tens_nxt_s     = MAX_TENS;
              ones_nxt_s     = MAX_ONES;
              overflow_nxt_s = 1'b1;
            end else begin
              tens_nxt_s = tens_step_s;
              ones_nxt_s = ones_step_s;
            end
          end else begin
            tens_nxt_s = tens_r;
            ones_nxt_s = ones_r;
          end
          // The run starts from the value including a coinciding press.
          if (toggle_rise_s && ((tens_nxt_s != 4'd0) || (ones_nxt_s != 4'd0))) begin
            state_nxt_s = RUN;
          end else begin
            state_nxt_s = ENTRY;
          end
        end
        RUN: begin
          if (!toggle) begin
            state_nxt_s = ENTRY;
            tick_nxt_s  = TICK_W'(0);
          end else if (tick_hit_s) begin
            tick_nxt_s = TICK_W'(0);
            tens_nxt_s = tens_step_s;
            ones_nxt_s = ones_step_s;
            if ((tens_step_s == 4'd0) && (ones_step_s == 4'd0)) begin
              state_nxt_s = ENTRY;
              done_nxt_s  = 1'b1;
            end else begin
              state_nxt_s = RUN;
            end
          end else begin
            tick_nxt_s = tick_r + TICK_W'(1);
          end
        end
        default: begin
          state_nxt_s = ENTRY;
          tick_nxt_s  = TICK_W'(0);
        end
      endcase
    end
  end

  // State, value and registered output pulses.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r    <= ENTRY;
      ones_r     <= 4'd0;
      tens_r     <= 4'd0;
      tick_r     <= TICK_W'(0);
      toggle_q_r <= 1'b1;
      running_r  <= 1'b0;
      done_r     <= 1'b0;
      overflow_r <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      ones_r     <= ones_nxt_s;
      tens_r     <= tens_nxt_s;
      tick_r     <= tick_nxt_s;
      toggle_q_r <= toggle;
      running_r  <= (state_nxt_s == RUN);
      done_r     <= done_nxt_s;
      overflow_r <= overflow_nxt_s;
    end
  end

  assign value_ones = ones_r;
  assign value_tens = tens_r;
  assign running    = running_r;
  assign done       = done_r;
  assign overflow   = overflow_r;

endmodule

// File: tb/tb_press_accumulator.sv
// Directed bench for press_accumulator with TICK_DIV=4 and MAX_VALUE=99.
module tb_press_accumulator;
  import press_pkg::*;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       press_valid = 1'b0;
  logic [1:0] press_type = 2'b00;
  logic       toggle = 1'b0;
  logic       clear = 1'b0;
  logic [3:0] value_ones, value_tens;
  logic       running, done, overflow;
  int         checks = 0;
  int         errors = 0;

  press_accumulator #(.MAX_VALUE(99), .TICK_DIV(4), .TICK_W(3)) dut (
    .clk(clk), .resetn(resetn), .press_valid(press_valid), .press_type(press_type),
    .toggle(toggle), .clear(clear), .value_ones(value_ones), .value_tens(value_tens),
    .running(running), .done(done), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [1:0] t);
    press_valid = 1'b1;
    press_type  = t;
    step();
    press_valid = 1'b0;
    press_type  = 2'b00;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    step();
    clear = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) step();
    checks++; if ({value_tens, value_ones, running, done, overflow} !== 11'h000) begin errors++; $display("FAIL reset_hold got %h%h r%b d%b o%b exp 00 r0 d0 o0", value_tens, value_ones, running, done, overflow); end
    resetn = 1'b1;
    step();
    repeat (3) press(PRESS_TEN);
    repeat (7) press(PRESS_ONE);
    checks++; if ({value_tens, value_ones} !== 8'h37) begin errors++; $display("FAIL reset_build got %h%h exp 37", value_tens, value_ones); end
    toggle = 1'b1;
    step();
    checks++; if (running !== 1'b1) begin errors++; $display("FAIL reset_run_start got %b exp 1", running); end
    step();
    #2 resetn = 1'b0;
    #1;
    checks++; if ({value_tens, value_ones} !== 8'h00) begin errors++; $display("FAIL reset_async_value got %h%h exp 00", value_tens, value_ones); end
    checks++; if ({running, done, overflow} !== 3'b000) begin errors++; $display("FAIL reset_async_flags got r%b d%b o%b exp 000", running, done, overflow); end
    step();
    resetn = 1'b1;
    repeat (3) step();
    press(PRESS_ONE);
    repeat (2) step();
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL reset_toggle_high got running %b exp 0", running); end
    checks++; if ({value_tens, value_ones} !== 8'h01) begin errors++; $display("FAIL reset_toggle_value got %h%h exp 01", value_tens, value_ones); end
    toggle = 1'b0;
    step();
    do_clear();
    checks++; if ({value_tens, value_ones} !== 8'h00) begin errors++; $display("FAIL clear_entry got %h%h exp 00", value_tens, value_ones); end
  endtask

  task automatic test_accumulate();
    logic [7:0] exp_tbl [5];
    logic [1:0] typ_tbl [5];
    exp_tbl = '{8'h01, 8'h02, 8'h03, 8'h13, 8'h23};
    typ_tbl = '{PRESS_ONE, PRESS_ONE, PRESS_ONE, PRESS_TEN, PRESS_TEN};
    do_clear();
    for (int i = 0; i < 5; i++) begin
      press(typ_tbl[i]);
      checks++; if ({value_tens, value_ones} !== exp_tbl[i]) begin errors++; $display("FAIL accum_%0d got %h%h exp %h", i, value_tens, value_ones, exp_tbl[i]); end
    end
    press(2'b11);
    checks++; if ({value_tens, value_ones, overflow} !== 9'h046) begin errors++; $display("FAIL accum_code11 got %h%h o%b exp 23 o0", value_tens, value_ones, overflow); end
    press(2'b00);
    checks++; if ({value_tens, value_ones, overflow} !== 9'h046) begin errors++; $display("FAIL accum_code00 got %h%h o%b exp 23 o0", value_tens, value_ones, overflow); end
  endtask

  task automatic test_carry_sat();
    do_clear();
    repeat (9) press(PRESS_ONE);
    checks++; if ({value_tens, value_ones} !== 8'h09) begin errors++; $display("FAIL carry_pre got %h%h exp 09", value_tens, value_ones); end
    press(PRESS_ONE);
    checks++; if ({value_tens, value_ones} !== 8'h10) begin errors++; $display("FAIL carry_09p1 got %h%h exp 10", value_tens, value_ones); end
    do_clear();
    repeat (9) press(PRESS_TEN);
    repeat (5) press(PRESS_ONE);
    checks++; if ({value_tens, value_ones, overflow} !== 9'h12A) begin errors++; $display("FAIL sat_pre got %h%h o%b exp 95 o0", value_tens, value_ones, overflow); end
    press(PRESS_TEN);
    checks++; if ({value_tens, value_ones, overflow} !== 9'h133) begin errors++; $display("FAIL sat_95p10 got %h%h o%b exp 99 o1", value_tens, value_ones, overflow); end
    step();
    checks++; if ({value_tens, value_ones, overflow} !== 9'h132) begin errors++; $display("FAIL sat_ovf_clear got %h%h o%b exp 99 o0", value_tens, value_ones, overflow); end
    press(PRESS_ONE);
    checks++; if ({value_tens, value_ones, overflow} !== 9'h133) begin errors++; $display("FAIL sat_99p1 got %h%h o%b exp 99 o1", value_tens, value_ones, overflow); end
    step();
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL sat_ovf_pulse got %b exp 0", overflow); end
  endtask

  task automatic test_countdown();
    do_clear();
    repeat (3) press(PRESS_ONE);
    toggle = 1'b1;
    step();
    checks++; if ({running, value_tens, value_ones} !== 9'h103) begin errors++; $display("FAIL cd_start got r%b %h%h exp r1 03", running, value_tens, value_ones); end
    repeat (3) step();
    checks++; if ({value_tens, value_ones} !== 8'h03) begin errors++; $display("FAIL cd_early got %h%h exp 03", value_tens, value_ones); end
    step();
    checks++; if ({running, value_tens, value_ones} !== 9'h102) begin errors++; $display("FAIL cd_step4 got r%b %h%h exp r1 02", running, value_tens, value_ones); end
    repeat (4) step();
    checks++; if ({running, value_tens, value_ones} !== 9'h101) begin errors++; $display("FAIL cd_step8 got r%b %h%h exp r1 01", running, value_tens, value_ones); end
    repeat (3) step();
    checks++; if ({done, running} !== 2'b01) begin errors++; $display("FAIL cd_pre_done got d%b r%b exp d0 r1", done, running); end
    step();
    checks++; if ({done, running, value_tens, value_ones} !== 10'h200) begin errors++; $display("FAIL cd_done got d%b r%b %h%h exp d1 r0 00", done, running, value_tens, value_ones); end
    step();
    checks++; if ({done, running} !== 2'b00) begin errors++; $display("FAIL cd_done_pulse got d%b r%b exp d0 r0", done, running); end
    toggle = 1'b0;
    step();
  endtask

  task automatic test_pause();
    do_clear();
    repeat (5) press(PRESS_ONE);
    toggle = 1'b1;
    step();
    checks++; if (running !== 1'b1) begin errors++; $display("FAIL pause_start got %b exp 1", running); end
    press(PRESS_ONE);
    checks++; if ({running, value_tens, value_ones} !== 9'h105) begin errors++; $display("FAIL pause_press_ignored got r%b %h%h exp r1 05", running, value_tens, value_ones); end
    repeat (2) step();
    step();
    checks++; if ({value_tens, value_ones} !== 8'h04) begin errors++; $display("FAIL pause_first_dec got %h%h exp 04", value_tens, value_ones); end
    toggle = 1'b0;
    step();
    checks++; if ({running, done, value_tens, value_ones} !== 10'h004) begin errors++; $display("FAIL pause_enter got r%b d%b %h%h exp r0 d0 04", running, done, value_tens, value_ones); end
    repeat (3) step();
    checks++; if ({value_tens, value_ones} !== 8'h04) begin errors++; $display("FAIL pause_hold got %h%h exp 04", value_tens, value_ones); end
    toggle = 1'b1;
    step();
    checks++; if (running !== 1'b1) begin errors++; $display("FAIL pause_resume got %b exp 1", running); end
    repeat (3) step();
    checks++; if ({value_tens, value_ones} !== 8'h04) begin errors++; $display("FAIL pause_resume_early got %h%h exp 04", value_tens, value_ones); end
    step();
    checks++; if ({value_tens, value_ones} !== 8'h03) begin errors++; $display("FAIL pause_resume_dec got %h%h exp 03", value_tens, value_ones); end
    toggle = 1'b0;
    step();
  endtask

  task automatic test_simultaneous();
    do_clear();
    toggle = 1'b1;
    press(PRESS_ONE);
    checks++; if ({running, value_tens, value_ones} !== 9'h101) begin errors++; $display("FAIL sim_press_toggle got r%b %h%h exp r1 01", running, value_tens, value_ones); end
    repeat (4) step();
    checks++; if ({done, running, value_tens, value_ones} !== 10'h200) begin errors++; $display("FAIL sim_done got d%b r%b %h%h exp d1 r0 00", done, running, value_tens, value_ones); end
    toggle = 1'b0;
    step();
  endtask

  task automatic test_clear_priority();
    do_clear();
    repeat (2) press(PRESS_ONE);
    toggle = 1'b1;
    step();
    repeat (3) step();
    checks++; if ({running, value_tens, value_ones} !== 9'h102) begin errors++; $display("FAIL clr_pre got r%b %h%h exp r1 02", running, value_tens, value_ones); end
    clear       = 1'b1;
    press_valid = 1'b1;
    press_type  = PRESS_TEN;
    step();
    clear       = 1'b0;
    press_valid = 1'b0;
    press_type  = 2'b00;
    checks++; if ({value_tens, value_ones} !== 8'h00) begin errors++; $display("FAIL clr_value got %h%h exp 00", value_tens, value_ones); end
    checks++; if ({running, done, overflow} !== 3'b000) begin errors++; $display("FAIL clr_flags got r%b d%b o%b exp 000", running, done, overflow); end
    toggle = 1'b0;
    step();
    toggle = 1'b1;
    step();
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL clr_zero_toggle got %b exp 0", running); end
    repeat (2) step();
    checks++; if ({running, done, value_tens, value_ones} !== 10'h000) begin errors++; $display("FAIL clr_zero_hold got r%b d%b %h%h exp r0 d0 00", running, done, value_tens, value_ones); end
    toggle = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_accumulate();
    test_carry_sat();
    test_countdown();
    test_pause();
    test_simultaneous();
    test_clear_priority();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
